// File: rtl/zone_pkg.sv
// Shared defaults, derived zone geometry, luma coefficients and encodings
// for the zone luma statistics block.
package zone_pkg;

    localparam int H_ACT_DEF  = 1920;
    localparam int V_ACT_DEF  = 1080;
    localparam int ZONE_X_DEF = 24;
    localparam int ZONE_Y_DEF = 15;

    localparam int ZW_DEF = H_ACT_DEF / ZONE_X_DEF;
    localparam int ZH_DEF = V_ACT_DEF / ZONE_Y_DEF;

    localparam int SUM_W      = 21;
    localparam int RECIP_W    = 25;
    localparam int MEAN_SHIFT = 24;

    // round(2^24 / area) using integer arithmetic only
    function automatic int unsigned recip(input int unsigned area);
        longint unsigned num;
        num = 64'd1 << (MEAN_SHIFT + 1);
        return 32'((num / 64'(area) + 64'd1) >> 1);
    endfunction

    localparam int unsigned RECIP_DEF = recip(ZW_DEF * ZH_DEF);

    localparam logic [7:0] COEF_R = 8'd77;
    localparam logic [7:0] COEF_G = 8'd150;
    localparam logic [7:0] COEF_B = 8'd29;

    typedef enum logic [1:0] {
        MODE_MAX   = 2'd0,
        MODE_MEAN  = 2'd1,
        MODE_BLEND = 2'd2,
        MODE_FULL  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_EMIT,
        S_DONE
    } state_e;

endpackage

// File: rtl/luma_calc.sv
// Two-stage luma pipeline: Y = (77R + 150G + 29B) >> 8, truncated.
module luma_calc
    import zone_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic [7:0] y
);

    logic [15:0] pr, pg, pb;
    logic [15:0] sum;

    // coefficients add to 256, so the weighted sum always fits 16 bits
    assign sum = pr + pg + pb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr <= '0;
            pg <= '0;
            pb <= '0;
            y  <= '0;
        end else begin
            pr <= 16'(r) * 16'(COEF_R);
            pg <= 16'(g) * 16'(COEF_G);
            pb <= 16'(b) * 16'(COEF_B);
            y  <= sum[15:8];
        end
    end

endmodule

// File: rtl/zone_luma_stat.sv
// Per-zone luma max/mean statistics over a frame, emitted row by row as a
// stream of ZONE_X*ZONE_Y brightness values.
module zone_luma_stat
    import zone_pkg::*;
#(
    parameter int H_ACT  = H_ACT_DEF,
    parameter int V_ACT  = V_ACT_DEF,
    parameter int ZONE_X = ZONE_X_DEF,
    parameter int ZONE_Y = ZONE_Y_DEF
) (
    input  logic       I_clk,
    input  logic       I_rst_n,
    input  logic       I_vs,
    input  logic       I_de,
    input  logic [7:0] I_r,
    input  logic [7:0] I_g,
    input  logic [7:0] I_b,
    input  logic [1:0] I_led_mode,
    output logic [7:0] O_led_light,
    output logic [8:0] O_cnt_360,
    output logic       O_valid,
    output logic       O_flag_done
);

    localparam int ZW  = H_ACT / ZONE_X;
    localparam int ZH  = V_ACT / ZONE_Y;
    localparam int XW  = $clog2(H_ACT + 1);
    localparam int YW  = $clog2(V_ACT + 1);
    localparam int ZCW = $clog2(ZW + 1);
    localparam int LYW = $clog2(ZH + 1);
    localparam int CW  = $clog2(ZONE_X + 1);

    localparam logic [XW-1:0]      X_LIM    = XW'(H_ACT);
    localparam logic [YW-1:0]      Y_LIM    = YW'(V_ACT);
    localparam logic [ZCW-1:0]     ZW_LAST  = ZCW'(ZW - 1);
    localparam logic [LYW-1:0]     LY_LAST  = LYW'(ZH - 1);
    localparam logic [CW-1:0]      COL_LAST = CW'(ZONE_X - 1);
    localparam logic [8:0]         IDX_LAST = 9'(ZONE_X * ZONE_Y - 1);
    localparam logic [RECIP_W-1:0] RECIP    = RECIP_W'(recip(ZW * ZH));

    state_e state;
    mode_e  mode;

    logic           vs_q, de_q, vs_rise, de_fall, pix_ok;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [ZCW-1:0] zcnt;
    logic [LYW-1:0] ly;
    logic [CW-1:0]  col, col_d1, col_d2, ecol;
    logic           ok_d1, ok_d2, re_d1, re_d2;
    logic [7:0]     luma;
    logic [8:0]     idx;

    logic [7:0]       bank_max [ZONE_X];
    logic [SUM_W-1:0] bank_sum [ZONE_X];
    logic [7:0]       snap_max [ZONE_X];
    logic [SUM_W-1:0] snap_sum [ZONE_X];

    logic [SUM_W+RECIP_W-1:0] prod;
    logic [SUM_W:0]           mean_wide;
    logic [7:0]               mean, max_v, light;

    assign vs_rise = I_vs & ~vs_q;
    assign de_fall = de_q & ~I_de;
    assign pix_ok  = I_de && (x < X_LIM) && (y < Y_LIM) && (state != S_IDLE);

    luma_calc u_luma (
        .clk  (I_clk),
        .rst_n(I_rst_n),
        .r    (I_r),
        .g    (I_g),
        .b    (I_b),
        .y    (luma)
    );

    // Counters run on raw I_de; the column tag and the zone-row-end marker are
    // delayed by two cycles so they line up with the luma pipeline output.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            vs_q   <= 1'b0;
            de_q   <= 1'b0;
            x      <= '0;
            y      <= '0;
            zcnt   <= '0;
            col    <= '0;
            ly     <= '0;
            ok_d1  <= 1'b0;
            ok_d2  <= 1'b0;
            col_d1 <= '0;
            col_d2 <= '0;
            re_d1  <= 1'b0;
            re_d2  <= 1'b0;
        end else begin
            vs_q   <= I_vs;
            de_q   <= I_de;
            ok_d1  <= pix_ok;
            ok_d2  <= ok_d1;
            col_d1 <= col;
            col_d2 <= col_d1;
            re_d1  <= 1'b0;
            re_d2  <= re_d1;
            if (vs_rise) begin
                x     <= '0;
                y     <= '0;
                zcnt  <= '0;
                col   <= '0;
                ly    <= '0;
                ok_d1 <= 1'b0;
                ok_d2 <= 1'b0;
                re_d2 <= 1'b0;
            end else if (I_de) begin
                if (x != X_LIM) x <= x + 1'b1;
                if (x < X_LIM) begin
                    if (zcnt == ZW_LAST) begin
                        zcnt <= '0;
                        if (col != COL_LAST) col <= col + 1'b1;
                    end else begin
                        zcnt <= zcnt + 1'b1;
                    end
                end
            end else if (de_fall) begin
                x    <= '0;
                zcnt <= '0;
                col  <= '0;
                if (y < Y_LIM) begin
                    y <= y + 1'b1;
                    if (ly == LY_LAST) begin
                        ly    <= '0;
                        re_d1 <= (state == S_ACCUM);
                    end else begin
                        ly <= ly + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            for (int unsigned i = 0; i < ZONE_X; i++) begin
                bank_max[i] <= '0;
                bank_sum[i] <= '0;
                snap_max[i] <= '0;
                snap_sum[i] <= '0;
            end
        end else if (vs_rise) begin
            for (int unsigned i = 0; i < ZONE_X; i++) begin
                bank_max[i] <= '0;
                bank_sum[i] <= '0;
            end
        end else if (re_d2) begin
            snap_max <= bank_max;
            snap_sum <= bank_sum;
            for (int unsigned i = 0; i < ZONE_X; i++) begin
                bank_max[i] <= '0;
                bank_sum[i] <= '0;
            end
        end else if (ok_d2) begin
            if (luma > bank_max[col_d2]) bank_max[col_d2] <= luma;
            bank_sum[col_d2] <= bank_sum[col_d2] + SUM_W'(luma);
        end
    end

    always_comb begin
        max_v     = snap_max[ecol];
        prod      = (SUM_W + RECIP_W)'(snap_sum[ecol]) * (SUM_W + RECIP_W)'(RECIP);
        mean_wide = (SUM_W + 1)'(prod >> MEAN_SHIFT);
        mean      = (mean_wide > (SUM_W + 1)'(255)) ? 8'hFF : mean_wide[7:0];
        light     = 8'hFF;
        case (mode)
            MODE_MAX:   light = max_v;
            MODE_MEAN:  light = mean;
            MODE_BLEND: light = 8'((9'(max_v) + 9'(mean) + 9'd1) >> 1);
            MODE_FULL:  light = 8'hFF;
            default:    light = 8'hFF;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state       <= S_IDLE;
            mode        <= MODE_MAX;
            ecol        <= '0;
            idx         <= '0;
            O_led_light <= '0;
            O_cnt_360   <= '0;
            O_valid     <= 1'b0;
            O_flag_done <= 1'b0;
        end else begin
            O_valid     <= 1'b0;
            O_flag_done <= 1'b0;
            if (vs_rise) begin
                state <= S_ACCUM;
                mode  <= mode_e'(I_led_mode);
                ecol  <= '0;
                idx   <= '0;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_ACCUM: begin
                        if (re_d2) begin
                            state <= S_EMIT;
                            ecol  <= '0;
                        end
                    end
                    S_EMIT: begin
                        O_valid     <= 1'b1;
                        O_led_light <= light;
                        O_cnt_360   <= idx;
                        idx         <= idx + 1'b1;
                        ecol        <= ecol + 1'b1;
                        if (ecol == COL_LAST)
                            state <= (idx == IDX_LAST) ? S_DONE : S_ACCUM;
                    end
                    S_DONE: begin
                        O_flag_done <= 1'b1;
                        state       <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_zone_luma_stat.sv
// Directed/randomized bench for zone_luma_stat on a reduced 96x60 raster
// (zones 4x4, 24x15 grid) against a frame-level reference model.
module tb_zone_luma_stat;

    localparam int H     = 96;
    localparam int V     = 60;
    localparam int ZX    = 24;
    localparam int ZY    = 15;
    localparam int ZW    = H / ZX;
    localparam int ZH    = V / ZY;
    localparam int BLANK = 4;
    localparam int XTRA  = 4;
    localparam int LTRA  = 2;
    localparam longint RECIP = ((longint'(1) << 25) / (ZW * ZH) + 1) >> 1;

    logic       I_clk = 1'b0;
    logic       I_rst_n, I_vs, I_de;
    logic [7:0] I_r, I_g, I_b;
    logic [1:0] I_led_mode;
    logic [7:0] O_led_light;
    logic [8:0] O_cnt_360;
    logic       O_valid, O_flag_done;

    zone_luma_stat #(.H_ACT(H), .V_ACT(V), .ZONE_X(ZX), .ZONE_Y(ZY)) dut (
        .I_clk      (I_clk),
        .I_rst_n    (I_rst_n),
        .I_vs       (I_vs),
        .I_de       (I_de),
        .I_r        (I_r),
        .I_g        (I_g),
        .I_b        (I_b),
        .I_led_mode (I_led_mode),
        .O_led_light(O_led_light),
        .O_cnt_360  (O_cnt_360),
        .O_valid    (O_valid),
        .O_flag_done(O_flag_done)
    );

    always #5 I_clk = ~I_clk;

    int tests = 0;
    int fails = 0;
    int img_r [V+LTRA][H+XTRA];
    int img_g [V+LTRA][H+XTRA];
    int img_b [V+LTRA][H+XTRA];
    int cap_idx[$];
    int cap_light[$];
    int exp_q[$];
    int cyc = 0, done_cnt = 0, done_cyc = -1, c359 = -1;
    int mchg_line = -1;
    logic [1:0] mchg_val = 2'd0;

    always @(negedge I_clk) begin
        cyc++;
        if (O_valid === 1'b1) begin
            cap_idx.push_back(int'(O_cnt_360));
            cap_light.push_back(int'(O_led_light));
            if (O_cnt_360 == 9'd359) c359 = cyc;
        end
        if (O_flag_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    function automatic int luma(input int l, input int p);
        return (77 * img_r[l][p] + 150 * img_g[l][p] + 29 * img_b[l][p]) >> 8;
    endfunction

    function automatic void fill(input int kind);
        for (int l = 0; l < V + LTRA; l++)
            for (int p = 0; p < H + XTRA; p++) begin
                int v;
                case (kind)
                    0: v = 100;
                    1: v = (l == ZH + 1 && p == ZW + 1) ? 255 : 0;
                    2: v = (l < ZH && p < ZW / 2) ? 200 : 0;
                    default: v = -1;
                endcase
                if (v < 0) begin
                    img_r[l][p] = int'($urandom_range(0, 255));
                    img_g[l][p] = int'($urandom_range(0, 255));
                    img_b[l][p] = int'($urandom_range(0, 255));
                end else begin
                    img_r[l][p] = v;
                    img_g[l][p] = v;
                    img_b[l][p] = v;
                end
            end
    endfunction

    function automatic void build_exp(input int mode, input int nlines);
        int rows;
        exp_q.delete();
        rows = ((nlines < V) ? nlines : V) / ZH;
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < ZX; c++) begin
                int mx = 0, sm = 0, mn;
                for (int yy = r * ZH; yy < (r + 1) * ZH; yy++)
                    for (int xx = c * ZW; xx < (c + 1) * ZW; xx++) begin
                        int lv = luma(yy, xx);
                        if (lv > mx) mx = lv;
                        sm += lv;
                    end
                mn = int'((longint'(sm) * RECIP) >> 24);
                if (mn > 255) mn = 255;
                case (mode)
                    0: exp_q.push_back(mx);
                    1: exp_q.push_back(mn);
                    2: exp_q.push_back((mx + mn + 1) >> 1);
                    default: exp_q.push_back(255);
                endcase
            end
    endfunction

    task automatic clear_cap();
        cap_idx.delete();
        cap_light.delete();
        done_cnt = 0;
        done_cyc = -1;
        c359 = -1;
    endtask

    task automatic start_frame(input logic [1:0] mode);
        clear_cap();
        I_led_mode = mode;
        I_vs = 1'b1;
        tick();
        tick();
        I_vs = 1'b0;
        repeat (4) tick();
    endtask

    task automatic drive_lines(input int first, input int last, input int hpix);
        for (int l = first; l <= last; l++) begin
            for (int p = 0; p < hpix; p++) begin
                I_r  = 8'(img_r[l][p]);
                I_g  = 8'(img_g[l][p]);
                I_b  = 8'(img_b[l][p]);
                I_de = 1'b1;
                tick();
            end
            I_de = 1'b0;
            I_r  = '0;
            I_g  = '0;
            I_b  = '0;
            if (l == mchg_line) I_led_mode = mchg_val;
            repeat (BLANK) tick();
        end
    endtask

    task automatic check_frame(input string tag, input int mode, input int nlines, input bit want_done);
        int f0 = fails;
        int n;
        build_exp(mode, nlines);
        chk({tag, "_count"}, cap_idx.size(), exp_q.size());
        n = (cap_idx.size() < exp_q.size()) ? cap_idx.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_idx"}, cap_idx[i], i);
            chk({tag, "_light"}, cap_light[i], exp_q[i]);
            if (fails != f0) break;
        end
        chk({tag, "_done_cnt"}, done_cnt, want_done ? 1 : 0);
        if (want_done) chk({tag, "_done_time"}, done_cyc, c359 + 1);
        if (exp_q.size() > 0) begin
            chk({tag, "_hold_idx"}, O_cnt_360, exp_q.size() - 1);
            chk({tag, "_hold_light"}, O_led_light, exp_q[exp_q.size() - 1]);
        end
    endtask

    initial begin
        int n;
        I_rst_n = 1'b0;
        I_vs = 1'b0;
        I_de = 1'b0;
        I_r = '0;
        I_g = '0;
        I_b = '0;
        I_led_mode = 2'd0;
        repeat (3) tick();
        chk("rst_valid", O_valid, 0);
        chk("rst_light", O_led_light, 0);
        chk("rst_cnt", O_cnt_360, 0);
        chk("rst_done", O_flag_done, 0);
        I_rst_n = 1'b1;
        repeat (3) tick();

        // uniform grey 100, max then mean
        fill(0);
        start_frame(2'd0); drive_lines(0, V - 1, H); repeat (40) tick();
        check_frame("uni_max", 0, V, 1'b1);
        start_frame(2'd1); drive_lines(0, V - 1, H); repeat (40) tick();
        check_frame("uni_mean", 1, V, 1'b1);

        // single bright pixel in zone (row 1, col 1) = index 25
        fill(1);
        start_frame(2'd0); drive_lines(0, V - 1, H); repeat (40) tick();
        check_frame("single_max", 0, V, 1'b1);
        if (cap_light.size() > 25) chk("single_idx25", cap_light[25], 255);
        start_frame(2'd1); drive_lines(0, V - 1, H); repeat (40) tick();
        check_frame("single_mean", 1, V, 1'b1);

        // zone 0 half 200 / half 0, blend -> 150
        fill(2);
        start_frame(2'd2); drive_lines(0, V - 1, H); repeat (40) tick();
        check_frame("half_blend", 2, V, 1'b1);
        if (cap_light.size() > 0) chk("half_idx0", cap_light[0], 150);

        // abort by I_vs in the middle of zone row 5 emission
        fill(3);
        start_frame(2'd1);
        drive_lines(0, 4 * ZH + ZH - 1 + ZH, H);
        repeat (6) tick();
        chk("abort_emitting", O_valid, 1);
        I_led_mode = 2'd2;
        I_vs = 1'b1;
        @(posedge I_clk);
        @(negedge I_clk);
        chk("abort_stop", O_valid, 0);
        n = cap_idx.size();
        build_exp(1, 6 * ZH);
        chk("abort_partial", 32'(n > 5 * ZX && n < 6 * ZX), 1);
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            int f0 = fails;
            chk("abort_idx", cap_idx[i], i);
            chk("abort_light", cap_light[i], exp_q[i]);
            if (fails != f0) break;
        end
        chk("abort_no_done", done_cnt, 0);
        clear_cap();
        fill(3);
        tick();
        I_vs = 1'b0;
        repeat (4) tick();
        drive_lines(0, V + LTRA - 1, H + XTRA); repeat (40) tick();
        check_frame("post_abort", 2, V + LTRA, 1'b1);

        // reset asserted during zone row 3 emission
        fill(3);
        start_frame(2'd0);
        drive_lines(0, 4 * ZH - 1, H);
        repeat (4) tick();
        chk("rst_mid_emitting", O_valid, 1);
        I_rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", O_valid, 0);
        chk("rst_mid_light", O_led_light, 0);
        chk("rst_mid_cnt", O_cnt_360, 0);
        chk("rst_mid_done", O_flag_done, 0);
        repeat (3) tick();
        I_rst_n = 1'b1;
        clear_cap();
        drive_lines(4 * ZH, V - 1, H); repeat (40) tick();
        chk("rst_wait_vs", cap_idx.size(), 0);
        chk("rst_no_done", done_cnt, 0);
        fill(3);
        start_frame(2'd1); drive_lines(0, V - 1, H); repeat (40) tick();
        check_frame("post_rst", 1, V, 1'b1);

        // mode 3 with a mid-frame mode change that must not take effect
        fill(3);
        mchg_line = 10;
        mchg_val = 2'd0;
        start_frame(2'd3); drive_lines(0, V - 1, H); repeat (40) tick();
        check_frame("mode3", 3, V, 1'b1);
        mchg_line = -1;
        fill(3);
        start_frame(I_led_mode); drive_lines(0, V - 1, H); repeat (40) tick();
        check_frame("mode_next", 0, V, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/zone_luma_stat.md
ZONE_LUMA_STAT -- requirements
Module: zone_luma_stat

Interface
REQ-001 Parameters, one per line (name, default, meaning):
 H_ACT, 1920, active pixels per line.
 V_ACT, 1080, active lines per frame.
 ZONE_X, 24, zone columns.
 ZONE_Y, 15, zone rows.
 ZONE_X*ZONE_Y = 360.
REQ-002 Ports, one per line (name, direction, width, meaning):
 I_clk  in  1  pixel clock; single clock domain.
 I_rst_n  in  1  asynchronous, active-low reset.
 I_vs  in  1  vertical sync, active high.
 I_de  in  1  active-video data enable.
 I_r, I_g, I_b  in  8 each  pixel colour.
 I_led_mode  in  2  statistic select.
 O_led_light  out  8  zone brightness.
 O_cnt_360  out  9  zone index 0..359, row-major.
 O_valid  out  1  O_led_light and O_cnt_360 valid this cycle.
 O_flag_done  out  1  one-cycle pulse after zone 359 is emitted.

Function
REQ-003 Luma, 2-cycle pipeline: Y = (77*R + 150*G + 29*B) >> 8, 8-bit result, truncated.
REQ-004 Frame start:
 - Rising edge of I_vs clears the pixel counter x, line counter y and all accumulators.
 - Rising edge of I_vs samples I_led_mode for the whole frame.
REQ-005 x increments on each I_de cycle and clears on I_de falling edge; y increments on each I_de falling edge.
REQ-006 Pixels with x >= H_ACT or y >= V_ACT are ignored.
REQ-007 Zone geometry:
 - Zone width ZW = H_ACT/ZONE_X (80); zone height ZH = V_ACT/ZONE_Y (72).
 - Column index = x/ZW, tracked by a ZW counter; no divider.
REQ-008 Per-column accumulator bank (ZONE_X entries):
 - Running maximum, 8 bits.
 - Running sum, 21 bits, no overflow at 5760*255.
REQ-009 Zone-row end: on the I_de falling edge of line (k+1)*ZH-1:
 - The bank is copied to a snapshot bank and cleared in the same cycle.
 - The next line accumulates with no loss of pixels.
REQ-010 Mean = (sum * RECIP) >> 24, where RECIP = round(2^24/(ZW*ZH)); result is saturated to 255.
REQ-011 Mode selects O_led_light:
 - 0: max.
 - 1: mean.
 - 2: (max + mean + 1) >> 1.
 - 3: constant 255.
REQ-012 FSM states and transitions:
 - IDLE -> ACCUM on I_vs rise.
 - ACCUM -> EMIT on zone-row end.
 - EMIT -> ACCUM after ZONE_X outputs, or -> DONE after zone row ZONE_Y-1.
 - DONE -> IDLE after one cycle.
REQ-013 EMIT timing:
 - First O_valid is no later than 4 cycles after the zone-row-end edge.
 - O_valid is then asserted on ZONE_X consecutive cycles.
 - O_cnt_360 = row*ZONE_X + col, col ascending.
REQ-014 O_flag_done is high for exactly one cycle: the cycle after O_valid for index 359.
REQ-015 Snapshot bank: EMIT reads only the snapshot, so I_de activity during EMIT does not corrupt output.
REQ-016 I_vs rise while not IDLE:
 - The current frame is aborted and any in-progress EMIT stops immediately.
 - O_flag_done is not asserted.
 - The FSM restarts in ACCUM for the new frame.
REQ-017 A frame with fewer than V_ACT lines:
 - Only complete zone rows are emitted.
 - No O_flag_done.
REQ-018 O_cnt_360 holds its last value and O_led_light holds its last value when O_valid is low.

Reset
REQ-019 While I_rst_n is low:
 - All outputs are 0 and the FSM is IDLE.
 - Counters, accumulators and snapshot bank are cleared.
 - Sampled mode is 0.
REQ-020 Reset asserted mid-EMIT ends emission within the same cycle (asynchronous); no O_flag_done is produced.
REQ-021 After reset release, the block waits for the next I_vs rise before accumulating.

Structure
REQ-022 Shared package zone_pkg holds:
 - H_ACT, V_ACT, ZONE_X, ZONE_Y defaults.
 - Derived ZW, ZH, RECIP.
 - Luma coefficients.
 - Mode encodings.
 - FSM state enum.
REQ-023 Sub-module luma_calc holds the REQ-003 pipeline; the remainder lives in zone_luma_stat.

Verification
REQ-024 Uniform frame R=G=B=100, mode 0 then mode 1 -> 360 outputs, each O_led_light=100; O_flag_done pulse after index 359.
REQ-025 Single pixel (x=85, y=75) = 255, rest 0:
 - Mode 0 -> index 25 = 255, all others 0.
 - Mode 1 -> index 25 = 0 (255/5760 truncates).
REQ-026 Zone 0 half 200 / half 0, mode 2 -> index 0 = (200+100+1)>>1 = 150.
REQ-027 I_vs pulse after line 500 -> indices 0..143 emitted, emission restarts from 0 in the new frame, no O_flag_done for the aborted frame.
REQ-028 I_rst_n low during EMIT of zone row 3 -> outputs 0 immediately; next frame emits cleanly from index 0.
REQ-029 Mode 3 with random pixels; I_led_mode changed mid-frame -> all outputs 255; change takes effect only at the next I_vs.
